// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, active video, strobes)
//
// Purpose:
//   Produces horizontal/vertical pixel counters, sync pulses, an active-video
//   flag and line/frame/pixel strobes. Every output is registered and decoded
//   from the next-count values, so hsync, vsync and video_on always describe
//   the hc/vc presented in the same cycle.
//
// Optional feature macro: VGA_TIMING_PIXDIV_EN
//   Defined   - a modulo-CLK_DIV divider gates counter advances; pix_tick
//               pulses once per CLK_DIV clocks.
//   Undefined - counters advance every clock; pix_tick is 1 out of reset.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   hc[10:0]     out  horizontal count, 0..H_TOTAL-1
//   vc[10:0]     out  vertical count, 0..V_TOTAL-1
//   hsync        out  horizontal sync, at HSYNC_POL while active
//   vsync        out  vertical sync, at VSYNC_POL while active
//   video_on     out  high inside the visible area
//   line_start   out  one-clk strobe on the first clk presenting hc==0
//   frame_start  out  one-clk strobe on the first clk presenting hc==0, vc==0
//   pix_tick     out  one-clk strobe on the first clk presenting a new (hc,vc)

module vga_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        pix_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 12-bit decode constants so comparisons against the 11-bit counts are
    // width-matched and a full 2048 total cannot overflow.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 2048) begin : g_h_total_chk
            $error("vga_timing_gen: H_TOTAL exceeds 2048");
        end
        if (V_TOTAL > 2048) begin : g_v_total_chk
            $error("vga_timing_gen: V_TOTAL exceeds 2048");
        end
        if (CLK_DIV < 1) begin : g_clk_div_chk
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic adv;

`ifdef VGA_TIMING_PIXDIV_EN
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Advance on the last phase of the divider; with CLK_DIV=1 the count
    // stays at 0 and every clock advances.
    always_comb begin
        adv   = (div_q == DIV_LAST);
        div_d = adv ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign adv = 1'b1;
`endif

    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        pix_tick_q, pix_tick_d;
    logic        in_hs;
    logic        in_vs;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (adv) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 11'd1;
            end else begin
                hc_d = hc_q + 11'd1;
            end
        end

        // Decode from the next counts so the registered flags line up with
        // the registered counts.
        in_hs         = ({1'b0, hc_d} >= HS_START) && ({1'b0, hc_d} < HS_END);
        in_vs         = ({1'b0, vc_d} >= VS_START) && ({1'b0, vc_d} < VS_END);
        hsync_d       = in_hs ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = in_vs ? VSYNC_POL : ~VSYNC_POL;
        video_on_d    = ({1'b0, hc_d} < H_ACT) && ({1'b0, vc_d} < V_ACT);
        pix_tick_d    = adv;
        line_start_d  = adv && (hc_d == 11'd0);
        frame_start_d = adv && (hc_d == 11'd0) && (vc_d == 11'd0);
    end

    // Reset parks the counters on the last position so the first advance
    // wraps to (0,0) and fires all strobes together.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_tick_q    <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pix_tick_q    <= pix_tick_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_tick    = pix_tick_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates VGA raster timing: horizontal and vertical pixel counters, sync pulses, an active-video flag, and line/frame strobes. It sits directly upstream of the dithering stage and the pixel source. Its `hc`/`vc` outputs drive the dithering stage's position inputs, and its `video_on` gates the final RGB output. The default timing is 1024x768@60 (65 MHz pixel rate).

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, hsync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `HSYNC_POL`, 0, active level of hsync (0 = active-low)
- `VSYNC_POL`, 0, active level of vsync
- `CLK_DIV`, 1, clk cycles per pixel; used only when the divider is compiled in (Configuration)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `hc`  out  11  horizontal count, 0..H_TOTAL-1
- `vc`  out  11  vertical count, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, at HSYNC_POL while active
- `vsync`  out  1  vertical sync, at VSYNC_POL while active
- `video_on`  out  1  high when hc < H_ACTIVE and vc < V_ACTIVE
- `line_start`  out  1  one-clk strobe on the first clk that presents hc==0
- `frame_start`  out  1  one-clk strobe on the first clk that presents hc==0 and vc==0
- `pix_tick`  out  1  one-clk strobe on the first clk that presents a new (hc,vc)

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, 1344 by default.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, 806 by default.
  - Both totals must be ≤2048; the block emits a `$error` at elaboration otherwise.
- Counting on each advance:
  - hc increments by 1.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, both wrap to 0.
- Region order per line: active, front porch, sync, back porch.
  - hsync is active for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on vc with the vertical parameters.
- All outputs are registered and mutually aligned: hsync, vsync and video_on always decode the hc/vc presented in the same cycle. The block computes them from the next-count values.
- Reset (synchronous, has priority over advancing):
  - hc=H_TOTAL-1, vc=V_TOTAL-1.
  - video_on=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - line_start, frame_start and pix_tick = 0; the divider count = 0.
  - The first advance after release wraps to (0,0) and fires frame_start, line_start and pix_tick together.
- Reset mid-frame abandons the current frame immediately; the block produces no partial-frame special handling.

## Timing
- Without the divider, counters advance on every clk edge with reset low.
  - The first edge after reset deasserts presents hc=0, vc=0, video_on=1, frame_start=1.
- Line period: H_TOTAL advances. Frame period: H_TOTAL×V_TOTAL advances.
- line_start, frame_start and pix_tick are exactly one clk wide regardless of CLK_DIV.
- Between advances, hc/vc are stable, so the downstream change detector sees exactly one change per pixel.

## Configuration
- Macro: `VGA_TIMING_PIXDIV_EN`.
- Defined:
  - An internal modulo-CLK_DIV counter (0..CLK_DIV-1) is compiled in.
  - Counters advance on the clk edge where the divider count equals CLK_DIV-1.
  - pix_tick is high for one clk of every CLK_DIV.
  - After reset, the first advance occurs CLK_DIV edges after release.
  - CLK_DIV=1 behaves identically to the undefined case.
- Undefined:
  - No divider logic; CLK_DIV is ignored.
  - Counters advance every clk; pix_tick is held at 1 whenever reset is low.
  - pix_tick is 0 during reset.

## Test plan
- Reset release, defaults, macro undefined → first edge: hc=0, vc=0, video_on=1, frame_start=1, line_start=1, hsync=1, vsync=1. Second edge: hc=1, frame_start=0.
- Horizontal region boundaries:
  - hc 1023→1024: video_on falls.
  - hsync=0 exactly for hc 1048..1183.
  - line_start recurs every 1344 clks.
- Vertical region boundaries:
  - vsync=0 exactly for vc 771..776.
  - video_on=0 for all of vc 768..805.
  - frame_start recurs after 1,083,264 clks.
- Small parameters (H: 4/1/2/1, V: 3/1/1/1, HSYNC_POL=1) → exhaustively compare two full frames (8×6 positions) against a reference model, including the wrap from (7,5) to (0,0).
- Reset asserted at hc=500, vc=300 → next edge: hc=1343, vc=805, video_on=0, syncs inactive. On release: wraps to (0,0) with frame_start=1.
- `VGA_TIMING_PIXDIV_EN` defined, CLK_DIV=4:
  - hc changes every 4 clks; pix_tick pattern is 1000 repeating.
  - frame_start is one clk wide.
  - The first (0,0) appears on the 4th edge after reset release.
